// File: rtl/enigma_core_param.sv
// enigma_core_param: parametrised Enigma core with loadable rotors, reflector and notches,
// one character in flight. Optional plugboard enabled by defining ENIGMA_PLUGBOARD_EN.
module enigma_core_param #(
   parameter int NUM_ROTORS = 3,
   parameter int ALPHA      = 26,
   parameter int SELW       = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [7:0]              din,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [7:0]              dout,
   output logic                    out_err,
   input  logic                    cfg_we,
   input  logic [SELW-1:0]         cfg_sel,
   input  logic [1:0]              cfg_kind,
   input  logic [7:0]              cfg_addr,
   input  logic [7:0]              cfg_data,
   output logic [8*NUM_ROTORS-1:0] pos_flat,
   output logic [2:0]              o_dbg_state
);
   localparam int AW = $clog2(ALPHA);
   localparam int KW = (NUM_ROTORS > 1) ? $clog2(NUM_ROTORS) : 1;
   localparam logic [8:0]      A9       = 9'(ALPHA);
   localparam logic [7:0]      AM1      = 8'(ALPHA - 1);
   localparam logic [KW-1:0]   K_LAST   = KW'(NUM_ROTORS - 1);
   localparam logic [SELW-1:0] SEL_REFL = SELW'(NUM_ROTORS);

   typedef enum logic [2:0] {S_IDLE, S_STEP, S_FWD, S_REFL, S_BWD, S_OUT} state_t;
   state_t r_state, w_next;

   logic [7:0]    r_fwd   [NUM_ROTORS][ALPHA];
   logic [7:0]    r_inv   [NUM_ROTORS][ALPHA];
   logic [7:0]    r_refl  [ALPHA];
   logic [7:0]    r_pos   [NUM_ROTORS];
   logic [7:0]    r_notch [NUM_ROTORS];
   logic [7:0]    r_c, r_dout;
   logic          r_bad, r_err;
   logic [KW-1:0] r_k;

   logic [7:0] w_p, w_in, w_t, w_rot_out, w_bwd_out, w_refl_out, w_cfg_mod;
   logic [8:0] w_sum, w_idx9, w_back, w_back9, w_mod9;
   logic [NUM_ROTORS-1:0] w_adv;
   logic          w_cfg_go, w_tab_ok, w_wr_refl;
   logic [KW-1:0] w_cfg_r;
   logic [AW-1:0] w_ca, w_cd;

   // Handshakes: a character transfers on a cycle with in_valid & in_ready; the result
   // (dout/out_err with out_valid) is held until a cycle with out_valid & out_ready.
   assign w_p       = r_pos[r_k];
   assign w_sum     = {1'b0, w_in} + {1'b0, w_p};
   assign w_idx9    = (w_sum >= A9) ? w_sum - A9 : w_sum;
   assign w_t       = (r_state == S_FWD) ? r_fwd[r_k][w_idx9[AW-1:0]] : r_inv[r_k][w_idx9[AW-1:0]];
   assign w_back    = {1'b0, w_t} + (A9 - {1'b0, w_p});
   assign w_back9   = (w_back >= A9) ? w_back - A9 : w_back;
   assign w_rot_out = w_back9[7:0];
   assign w_refl_out = r_refl[r_c[AW-1:0]];

   assign w_cfg_go  = cfg_we && (r_state == S_IDLE);
   assign w_tab_ok  = ({1'b0, cfg_addr} < A9) && ({1'b0, cfg_data} < A9);
   assign w_wr_refl = w_cfg_go && (cfg_sel == SEL_REFL) && (cfg_kind == 2'd0) && w_tab_ok;
   assign w_mod9    = {1'b0, cfg_data} % A9;
   assign w_cfg_mod = w_mod9[7:0];
   assign w_cfg_r   = cfg_sel[KW-1:0];
   assign w_ca      = cfg_addr[AW-1:0];
   assign w_cd      = cfg_data[AW-1:0];

`ifdef ENIGMA_PLUGBOARD_EN
   localparam logic [SELW-1:0] SEL_PLUG = SELW'(NUM_ROTORS + 1);
   logic [7:0] r_plug [ALPHA];
   logic       w_wr_plug;
   assign w_wr_plug = w_cfg_go && (cfg_sel == SEL_PLUG) && (cfg_kind == 2'd0) && w_tab_ok;
   assign w_in      = (r_state == S_FWD && r_k == '0) ? r_plug[r_c[AW-1:0]] : r_c;
   assign w_bwd_out = (r_k == '0) ? r_plug[w_rot_out[AW-1:0]] : w_rot_out;
`else
   assign w_in      = r_c;
   assign w_bwd_out = w_rot_out;
`endif

   // Odometer: a rotor advances only when every lower rotor advances from its notch.
   always_comb begin
      logic v_carry;
      v_carry = 1'b1;
      for (int i = 0; i < NUM_ROTORS; i++) begin
         w_adv[i] = v_carry;
         v_carry  = v_carry & (r_pos[i] == r_notch[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_next = S_STEP;
         S_STEP: w_next = S_FWD;
         S_FWD:  if (r_k == K_LAST) w_next = S_REFL;
         S_REFL: w_next = S_BWD;
         S_BWD:  if (r_k == '0) w_next = S_OUT;
         S_OUT:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (r_state == S_IDLE);
      out_valid   = (r_state == S_OUT);
      o_dbg_state = r_state;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_ROTORS; r++) begin
            for (int i = 0; i < ALPHA; i++) begin
               r_fwd[r][i] <= 8'(i);
               r_inv[r][i] <= 8'(i);
            end
            r_pos[r]   <= 8'd0;
            r_notch[r] <= AM1;
         end
         for (int i = 0; i < ALPHA; i++) begin
            r_refl[i] <= 8'(i ^ 1);
`ifdef ENIGMA_PLUGBOARD_EN
            r_plug[i] <= 8'(i);
`endif
         end
         r_c    <= 8'd0;
         r_dout <= 8'd0;
         r_bad  <= 1'b0;
         r_err  <= 1'b0;
         r_k    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_cfg_go && cfg_sel < SEL_REFL) begin
                  case (cfg_kind)
                     2'd0: if (w_tab_ok) begin
                        r_fwd[w_cfg_r][w_ca] <= cfg_data;
                        r_inv[w_cfg_r][w_cd] <= cfg_addr;
                     end
                     2'd1: r_pos[w_cfg_r]   <= w_cfg_mod;
                     2'd2: r_notch[w_cfg_r] <= w_cfg_mod;
                     default: ;
                  endcase
               end
               if (w_wr_refl) begin
                  r_refl[w_ca] <= cfg_data;
                  r_refl[w_cd] <= cfg_addr;
               end
`ifdef ENIGMA_PLUGBOARD_EN
               if (w_wr_plug) begin
                  r_plug[w_ca] <= cfg_data;
                  r_plug[w_cd] <= cfg_addr;
               end
`endif
               if (in_valid) begin
                  r_c   <= din;
                  r_bad <= ({1'b0, din} >= A9);
                  r_err <= 1'b0;
               end
            end
            S_STEP: begin
               r_k <= '0;
               if (!r_bad) begin
                  for (int i = 0; i < NUM_ROTORS; i++)
                     if (w_adv[i]) r_pos[i] <= (r_pos[i] == AM1) ? 8'd0 : r_pos[i] + 8'd1;
               end
            end
            S_FWD: begin
               if (!r_bad) r_c <= w_rot_out;
               if (r_k != K_LAST) r_k <= r_k + 1'b1;
            end
            S_REFL: if (!r_bad) r_c <= w_refl_out;
            S_BWD: begin
               if (!r_bad) r_c <= w_bwd_out;
               // An out-of-range character bypasses the rotors, so r_c still holds din.
               if (r_k == '0) begin
                  r_dout <= r_bad ? r_c : w_bwd_out;
                  r_err  <= r_bad;
               end else begin
                  r_k <= r_k - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_pos
      assign pos_flat[8*g +: 8] = r_pos[g];
   end

   assign dout    = r_dout;
   assign out_err = r_err;
endmodule

// File: tb/tb_enigma_core_param.sv
// tb_enigma_core_param: directed table and sequence checks of enigma_core_param
// with NUM_ROTORS=3, ALPHA=26.
module tb_enigma_core_param;
   logic        clk = 1'b0;
   logic        reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cfg_we = 1'b0;
   logic [7:0]  din = 8'd0, cfg_addr = 8'd0, cfg_data = 8'd0;
   logic [3:0]  cfg_sel = 4'd0;
   logic [1:0]  cfg_kind = 2'd0;
   logic        in_ready, out_valid, out_err;
   logic [7:0]  dout;
   logic [23:0] pos_flat;
   logic [2:0]  dbg_state;

   int checks = 0, errors = 0;
   logic [7:0] exp_q[$];

   enigma_core_param #(.NUM_ROTORS(3), .ALPHA(26), .SELW(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .din(din),
      .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .out_err(out_err),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_kind(cfg_kind), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .pos_flat(pos_flat), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0]  din;
      logic [7:0]  dout;
      logic        err;
      logic [23:0] pos;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic cfg_write(input int sel, input int kind, input int addr, input int data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_sel = 4'(sel); cfg_kind = 2'(kind);
      cfg_addr = 8'(addr); cfg_data = 8'(data);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Called at the first negedge after acceptance; counts cycles since the acceptance cycle.
   task automatic wait_out(output int cyc);
      int cnt;
      cnt = 1;
      while (!out_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      cyc = cnt;
      check("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic encrypt(input logic [7:0] ch, output logic [7:0] res, output logic err,
                          output int lat);
      @(negedge clk);
      in_valid = 1'b1; din = ch;
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat);
      res = dout; err = out_err;
      @(negedge clk);
   endtask

   initial begin
      logic [7:0] res;
      logic       err;
      int         lat, seen;
      logic [7:0] exp_plug;

      vecs[0] = '{8'd0,   8'd1,   1'b0, 24'h000001};
      vecs[1] = '{8'd7,   8'd6,   1'b0, 24'h000002};
      vecs[2] = '{8'd25,  8'd24,  1'b0, 24'h000003};
      vecs[3] = '{8'd30,  8'd30,  1'b1, 24'h000003};
      vecs[4] = '{8'd12,  8'd13,  1'b0, 24'h000004};
      vecs[5] = '{8'd255, 8'd255, 1'b1, 24'h000004};
      vecs[6] = '{8'd1,   8'd0,   1'b0, 24'h000005};

      do_reset();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      check("rst_pos", 32'(pos_flat), 32'd0);

      // Default wiring: identity rotors, reflector i^1.
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(vecs[i].dout);
         encrypt(vecs[i].din, res, err, lat);
         check($sformatf("tbl%0d_dout", i), 32'(res), 32'(exp_q.pop_front()));
         check($sformatf("tbl%0d_err", i), 32'(err), 32'(vecs[i].err));
         check($sformatf("tbl%0d_pos", i), 32'(pos_flat), 32'(vecs[i].pos));
         check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd9);
      end

      // Carry and notch handling.
      do_reset();
      cfg_write(0, 1, 0, 25);
      cfg_write(0, 2, 0, 25);
      cfg_write(1, 1, 0, 0);
      encrypt(8'd5, res, err, lat);
      check("carry1_dout", 32'(res), 32'd4);
      check("carry1_pos", 32'(pos_flat), 32'h000100);
      cfg_write(0, 1, 0, 25);
      cfg_write(1, 1, 0, 25);
      encrypt(8'd9, res, err, lat);
      check("carry2_pos", 32'(pos_flat), 32'h010000);
      cfg_write(0, 2, 0, 29);
      cfg_write(0, 1, 0, 28);
      check("pos_mod_load", 32'(pos_flat), 32'h010002);
      encrypt(8'd4, res, err, lat);
      check("notch_before_pos", 32'(pos_flat), 32'h010003);
      encrypt(8'd4, res, err, lat);
      check("notch_at_pos", 32'(pos_flat), 32'h010104);

      // Reciprocity: rotor0 = shift by 3, reflector pairs (i, 25-i).
      do_reset();
      for (int i = 0; i < 26; i++) cfg_write(0, 0, i, (i + 3) % 26);
      for (int i = 0; i < 13; i++) cfg_write(3, 0, i, 25 - i);
      encrypt(8'd7, res, err, lat);
      check("recip_enc", 32'(res), 32'd12);
      for (int r = 0; r < 3; r++) cfg_write(r, 1, 0, 0);
      encrypt(res, res, err, lat);
      check("recip_dec", 32'(res), 32'd7);

      // Config and character offered in the same idle cycle.
      @(negedge clk);
      cfg_we = 1'b1; cfg_sel = 4'd0; cfg_kind = 2'd1; cfg_addr = 8'd0; cfg_data = 8'd10;
      in_valid = 1'b1; din = 8'd2;
      @(negedge clk);
      cfg_we = 1'b0; in_valid = 1'b0;
      wait_out(lat);
      check("samecyc_dout", 32'(dout), 32'd17);
      check("samecyc_pos", 32'(pos_flat), 32'h00000B);
      @(negedge clk);

      // Position-dependent rotor: rotor1 swaps 0 and 1, rotor1 position 5.
      do_reset();
      cfg_write(1, 0, 0, 1);
      cfg_write(1, 0, 1, 0);
      cfg_write(1, 1, 0, 5);
      encrypt(8'd20, res, err, lat);
      check("rot1_enc20", 32'(res), 32'd22);
      encrypt(8'd22, res, err, lat);
      check("rot1_enc22", 32'(res), 32'd20);
      encrypt(8'd21, res, err, lat);
      check("rot1_enc21", 32'(res), 32'd23);

      // Out-of-range config writes are ignored.
      cfg_write(3, 0, 3, 30);
      cfg_write(1, 0, 30, 2);
      cfg_write(5, 1, 0, 7);
      encrypt(8'd3, res, err, lat);
      check("badcfg_dout", 32'(res), 32'd2);
      cfg_write(4, 0, 0, 5);
`ifdef ENIGMA_PLUGBOARD_EN
      exp_plug = 8'd4;
`else
      exp_plug = 8'd1;
`endif
      encrypt(8'd0, res, err, lat);
      check("plug_dout", 32'(res), 32'(exp_plug));
      check("badcfg_pos", 32'(pos_flat), 32'h000505);

      // Backpressure: result held, second character waits for the handshake.
      do_reset();
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; din = 8'd3;
      @(negedge clk);
      din = 8'd9;
      wait_out(lat);
      check("bp_lat", 32'(lat), 32'd9);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d_dout", i), 32'(dout), 32'd2);
         check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_idle_after_hs", 32'(in_ready), 32'd1);
      check("bp_pos_one_step", 32'(pos_flat), 32'h000001);
      @(negedge clk);
      in_valid = 1'b0;
      wait_out(lat);
      check("bp_second_lat", 32'(lat), 32'd9);
      check("bp_second_dout", 32'(dout), 32'd8);
      check("bp_second_pos", 32'(pos_flat), 32'h000002);
      @(negedge clk);

      // Config while busy is ignored.
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; din = 8'd0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      cfg_we = 1'b1; cfg_sel = 4'd1; cfg_kind = 2'd0; cfg_addr = 8'd0; cfg_data = 8'd5;
      @(negedge clk);
      cfg_sel = 4'd2; cfg_kind = 2'd1; cfg_data = 8'd7;
      @(negedge clk);
      cfg_we = 1'b0;
      wait_out(lat);
      check("busycfg_dout1", 32'(dout), 32'd1);
      @(negedge clk);
      encrypt(8'd0, res, err, lat);
      check("busycfg_dout2", 32'(res), 32'd1);
      check("busycfg_pos", 32'(pos_flat), 32'h000002);

      // Reset during REFL discards the character.
      do_reset();
      @(negedge clk);
      in_valid = 1'b1; din = 8'd4;
      @(negedge clk);
      in_valid = 1'b0;
      check("pos_in_step_cycle", 32'(pos_flat), 32'h000000);
      @(negedge clk);
      check("pos_after_step", 32'(pos_flat), 32'h000001);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rrefl_out_valid", 32'(out_valid), 32'd0);
      check("rrefl_in_ready", 32'(in_ready), 32'd1);
      check("rrefl_pos", 32'(pos_flat), 32'h000000);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("rrefl_discard", 32'(seen), 32'd0);
      encrypt(8'd4, res, err, lat);
      check("rrefl_next_dout", 32'(res), 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
